ext_pipe: RTL and testbench

- Parametrised, pipelined immediate extender for the pipelined CPU; sits between instruction decode and the ID/EX boundary.
- Takes the raw immediate and shamt fields plus an extension mode and produces a DATA_W-bit operand through STAGES elastic register slices with valid/ready handshake.
- Adds LUI-style upper placement and branch-offset (sign-extend, shift-left-2) modes.
- Adds pipeline flush, an illegal-mode flag and a saturating illegal-mode counter.

---
 rtl/ext_pipe.sv | 118 +++++++++++
 tb/tb_ext_pipe.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_pipe.sv
`default_nettype none
// ============================================================
// ext_pipe : immediate extender behind STAGES elastic slices
// Rev 1.0
// ============================================================
module ext_pipe #(
  parameter int DATA_W  = 32,
  parameter int IMM_W   = 16,
  parameter int SHAMT_W = 5,
  parameter int STAGES  = 1,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IMM_W-1:0]   i_imm,
  input  logic [SHAMT_W-1:0] i_shamt,
  input  logic [2:0]         ext_op,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  ext_out,
  output logic               out_err,
  output logic [CNT_W-1:0]   err_cnt
);

  localparam logic [2:0] c_OP_SEXT   = 3'b000;
  localparam logic [2:0] c_OP_ZEXT   = 3'b001;
  localparam logic [2:0] c_OP_SHAMT  = 3'b010;
  localparam logic [2:0] c_OP_UPPER  = 3'b011;
  localparam logic [2:0] c_OP_BRANCH = 3'b100;

  logic [DATA_W-1:0] w_sext;
  logic [DATA_W-1:0] w_ext;
  logic              w_illegal;
  logic              w_accept;
  logic [STAGES-1:0] w_valid;
  logic [STAGES-1:0] w_err;
  logic [STAGES-1:0] w_ready;
  logic [DATA_W-1:0] w_data [STAGES];
  logic [CNT_W-1:0]  r_err_cnt;

  assign w_sext = {{(DATA_W-IMM_W){i_imm[IMM_W-1]}}, i_imm};

  always_comb begin
    w_ext     = '0;
    w_illegal = 1'b0;
    case (ext_op)
      c_OP_SEXT:   w_ext = w_sext;
      c_OP_ZEXT:   w_ext = {{(DATA_W-IMM_W){1'b0}}, i_imm};
      c_OP_SHAMT:  w_ext = {{(DATA_W-SHAMT_W){1'b0}}, i_shamt};
      c_OP_UPPER:  w_ext = {i_imm, {(DATA_W-IMM_W){1'b0}}};
      c_OP_BRANCH: w_ext = w_sext << 2;
      default:     w_illegal = 1'b1;
    endcase
  end

  assign in_ready = !flush && w_ready[0];
  assign w_accept = in_valid && in_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    logic              r_v;
    logic              r_e;
    logic [DATA_W-1:0] r_d;
    logic              w_src_v;
    logic              w_src_e;
    logic [DATA_W-1:0] w_src_d;

    if (k == 0) begin : g_head
      assign w_src_v = w_accept;
      assign w_src_e = w_illegal;
      assign w_src_d = w_ext;
    end else begin : g_body
      assign w_src_v = w_valid[k-1];
      assign w_src_e = w_err[k-1];
      assign w_src_d = w_data[k-1];
    end

    // A slice can load unless it and every slice downstream of it is full and the consumer stalls.
    assign w_ready[k] = out_ready || !(&w_valid[STAGES-1:k]);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v <= 1'b0;
        r_e <= 1'b0;
        r_d <= '0;
      end else begin
        if (flush)
          r_v <= 1'b0;
        else if (w_ready[k])
          r_v <= w_src_v;
        if (w_ready[k] && w_src_v) begin
          r_d <= w_src_d;
          r_e <= w_src_e;
        end
      end
    end

    assign w_valid[k] = r_v;
    assign w_err[k]   = r_e;
    assign w_data[k]  = r_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_err_cnt <= '0;
    else if (w_accept && w_illegal && (r_err_cnt != '1))
      r_err_cnt <= r_err_cnt + CNT_W'(1);
  end

  assign out_valid = w_valid[STAGES-1];
  assign ext_out   = w_data[STAGES-1];
  assign out_err   = w_err[STAGES-1];
  assign err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ext_pipe.sv
`default_nettype none
// ============================================================
// tb_ext_pipe : randomized bench for ext_pipe, STAGES=1 and STAGES=3
// Rev 1.0
// ============================================================
module tb_ext_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        flush;
  logic        out_ready;
  logic [15:0] imm;
  logic [4:0]  shamt;
  logic [2:0]  op;

  logic        r1_rdy, o1_valid, o1_err;
  logic [31:0] o1_ext;
  logic [7:0]  o1_cnt;
  logic        r3_rdy, o3_valid, o3_err;
  logic [31:0] o3_ext;
  logic [1:0]  o3_cnt;

  int n_cmp  = 0;
  int n_fail = 0;
  int e1 = 0;
  int e3 = 0;

  always #5 clk = ~clk;

  ext_pipe #(.DATA_W(32), .IMM_W(16), .SHAMT_W(5), .STAGES(1), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r1_rdy),
    .i_imm(imm), .i_shamt(shamt), .ext_op(op), .flush(flush),
    .out_valid(o1_valid), .out_ready(out_ready), .ext_out(o1_ext),
    .out_err(o1_err), .err_cnt(o1_cnt)
  );

  ext_pipe #(.DATA_W(32), .IMM_W(16), .SHAMT_W(5), .STAGES(3), .CNT_W(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r3_rdy),
    .i_imm(imm), .i_shamt(shamt), .ext_op(op), .flush(flush),
    .out_valid(o3_valid), .out_ready(out_ready), .ext_out(o3_ext),
    .out_err(o3_err), .err_cnt(o3_cnt)
  );

  // Reference: {err, value} computed with signed arithmetic on the field values.
  function automatic logic [32:0] ref_ext(input logic [2:0] f_op, input logic [15:0] f_imm,
                                          input logic [4:0] f_sh);
    logic signed [31:0] s;
    s = $signed(f_imm);
    case (f_op)
      3'd0:    return {1'b0, s};
      3'd1:    return {1'b0, 32'(f_imm)};
      3'd2:    return {1'b0, 32'(f_sh)};
      3'd3:    return {1'b0, 32'(f_imm) * 32'd65536};
      3'd4:    return {1'b0, s * 32'sd4};
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    imm = '0; shamt = '0; op = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (o1_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid_s1: got %b want 0", o1_valid); end
    n_cmp++; if (o1_ext !== 32'd0) begin n_fail++; $display("FAIL reset_ext_s1: got %h want 0", o1_ext); end
    n_cmp++; if (o1_err !== 1'b0) begin n_fail++; $display("FAIL reset_err_s1: got %b want 0", o1_err); end
    n_cmp++; if (o1_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt_s1: got %0d want 0", o1_cnt); end
    n_cmp++; if (o3_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid_s3: got %b want 0", o3_valid); end
    n_cmp++; if (o3_ext !== 32'd0) begin n_fail++; $display("FAIL reset_ext_s3: got %h want 0", o3_ext); end
    n_cmp++; if (o3_err !== 1'b0) begin n_fail++; $display("FAIL reset_err_s3: got %b want 0", o3_err); end
    n_cmp++; if (o3_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_cnt_s3: got %0d want 0", o3_cnt); end
    rst_n = 1'b1;
    #2;
    n_cmp++; if (r1_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_ready_s1: got %b want 1", r1_rdy); end
    n_cmp++; if (r3_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_ready_s3: got %b want 1", r3_rdy); end
    @(posedge clk); #1;
    e1 = 0; e3 = 0;
  endtask

  task automatic test_illegal();
    logic [2:0] ops [5];
    ops[0] = 3'd5; ops[1] = 3'd6; ops[2] = 3'd7; ops[3] = 3'd5; ops[4] = 3'd6;
    out_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (c < 5) begin
        in_valid = 1'b1; op = ops[c]; imm = 16'($urandom); shamt = 5'($urandom);
      end else
        in_valid = 1'b0;
      @(posedge clk); #1;
      if (c < 5) begin
        n_cmp++; if (o1_valid !== 1'b1 || o1_ext !== 32'd0 || o1_err !== 1'b1) begin
          n_fail++; $display("FAIL illegal_out_s1[%0d]: got v=%b d=%h e=%b want v=1 d=0 e=1", c, o1_valid, o1_ext, o1_err);
        end
      end
      if (c >= 2) begin
        n_cmp++; if (o3_valid !== 1'b1 || o3_ext !== 32'd0 || o3_err !== 1'b1) begin
          n_fail++; $display("FAIL illegal_out_s3[%0d]: got v=%b d=%h e=%b want v=1 d=0 e=1", c, o3_valid, o3_ext, o3_err);
        end
      end
      if (c == 2) begin
        n_cmp++; if (o1_cnt !== 8'd3) begin n_fail++; $display("FAIL illegal_cnt3_s1: got %0d want 3", o1_cnt); end
        n_cmp++; if (o3_cnt !== 2'd3) begin n_fail++; $display("FAIL illegal_cnt3_s3: got %0d want 3", o3_cnt); end
      end
      if (c == 4) begin
        n_cmp++; if (o1_cnt !== 8'd5) begin n_fail++; $display("FAIL illegal_cnt5_s1: got %0d want 5", o1_cnt); end
        n_cmp++; if (o3_cnt !== 2'd3) begin n_fail++; $display("FAIL illegal_sat_s3: got %0d want 3", o3_cnt); end
      end
    end
    e1 = e1 + 5;
    e3 = 3;
  endtask

  task automatic test_modes();
    logic [2:0]  ops  [12];
    logic [15:0] imms [12];
    logic [4:0]  shs  [12];
    logic [31:0] exps [12];
    logic [32:0] r;
    ops[0] = 3'd0; imms[0] = 16'h8001; shs[0] = 5'h00; exps[0] = 32'hFFFF8001;
    ops[1] = 3'd1; imms[1] = 16'h8001; shs[1] = 5'h00; exps[1] = 32'h00008001;
    ops[2] = 3'd2; imms[2] = 16'h0000; shs[2] = 5'h1F; exps[2] = 32'h0000001F;
    ops[3] = 3'd3; imms[3] = 16'h1234; shs[3] = 5'h00; exps[3] = 32'h12340000;
    ops[4] = 3'd4; imms[4] = 16'hFFFF; shs[4] = 5'h00; exps[4] = 32'hFFFFFFFC;
    ops[5] = 3'd4; imms[5] = 16'h7FFF; shs[5] = 5'h00; exps[5] = 32'h0001FFFC;
    for (int i = 6; i < 12; i++) begin
      ops[i] = 3'($urandom_range(0, 4)); imms[i] = 16'($urandom); shs[i] = 5'($urandom);
      r = ref_ext(ops[i], imms[i], shs[i]);
      exps[i] = r[31:0];
    end
    out_ready = 1'b1;
    for (int c = 0; c < 15; c++) begin
      if (c < 12) begin
        in_valid = 1'b1; op = ops[c]; imm = imms[c]; shamt = shs[c];
      end else
        in_valid = 1'b0;
      #3;
      n_cmp++; if (r1_rdy !== 1'b1 || r3_rdy !== 1'b1) begin
        n_fail++; $display("FAIL modes_ready[%0d]: got s1=%b s3=%b want 1/1", c, r1_rdy, r3_rdy);
      end
      @(posedge clk); #1;
      if (c < 12) begin
        n_cmp++; if (o1_valid !== 1'b1 || o1_ext !== exps[c] || o1_err !== 1'b0) begin
          n_fail++; $display("FAIL modes_s1[%0d]: got v=%b d=%h e=%b want v=1 d=%h e=0", c, o1_valid, o1_ext, o1_err, exps[c]);
        end
      end else begin
        n_cmp++; if (o1_valid !== 1'b0) begin n_fail++; $display("FAIL modes_drain_s1[%0d]: got v=%b want 0", c, o1_valid); end
      end
      if (c >= 2 && c < 14) begin
        n_cmp++; if (o3_valid !== 1'b1 || o3_ext !== exps[c-2] || o3_err !== 1'b0) begin
          n_fail++; $display("FAIL modes_s3[%0d]: got v=%b d=%h e=%b want v=1 d=%h e=0", c, o3_valid, o3_ext, o3_err, exps[c-2]);
        end
      end else begin
        n_cmp++; if (o3_valid !== 1'b0) begin n_fail++; $display("FAIL modes_latency_s3[%0d]: got v=%b want 0", c, o3_valid); end
      end
    end
  endtask

  task automatic test_stream(input int n, input int stall_at, input int stall_len);
    logic [32:0] q1 [$];
    logic [32:0] q3 [$];
    logic [32:0] r;
    logic [2:0]  cop;
    logic [15:0] cimm;
    logic [4:0]  csh;
    logic        st1, st3, exp_rdy;
    logic [31:0] h1, h3;
    int          sent, cyc;
    sent = 0; cyc = 0; st1 = 1'b0; st3 = 1'b0; h1 = '0; h3 = '0;
    cop = 3'($urandom_range(0, 7)); cimm = 16'($urandom); csh = 5'($urandom);
    while ((sent < n || q1.size() != 0 || q3.size() != 0) && cyc < 400) begin
      in_valid = (sent < n); op = cop; imm = cimm; shamt = csh;
      out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      #3;
      exp_rdy = (q1.size() < 1) || out_ready;
      n_cmp++; if (r1_rdy !== exp_rdy) begin n_fail++; $display("FAIL stream_ready_s1[%0d]: got %b want %b", cyc, r1_rdy, exp_rdy); end
      exp_rdy = (q3.size() < 3) || out_ready;
      n_cmp++; if (r3_rdy !== exp_rdy) begin n_fail++; $display("FAIL stream_ready_s3[%0d]: got %b want %b", cyc, r3_rdy, exp_rdy); end
      n_cmp++; if (o1_cnt !== e1[7:0] || o3_cnt !== e3[1:0]) begin
        n_fail++; $display("FAIL stream_cnt[%0d]: got %0d/%0d want %0d/%0d", cyc, o1_cnt, o3_cnt, e1, e3);
      end
      if (st1) begin
        n_cmp++; if (o1_valid !== 1'b1 || o1_ext !== h1) begin
          n_fail++; $display("FAIL stream_hold_s1[%0d]: got v=%b d=%h want v=1 d=%h", cyc, o1_valid, o1_ext, h1);
        end
      end
      if (st3) begin
        n_cmp++; if (o3_valid !== 1'b1 || o3_ext !== h3) begin
          n_fail++; $display("FAIL stream_hold_s3[%0d]: got v=%b d=%h want v=1 d=%h", cyc, o3_valid, o3_ext, h3);
        end
      end
      if (o1_valid && out_ready) begin
        n_cmp++;
        if (q1.size() == 0) begin n_fail++; $display("FAIL stream_extra_s1[%0d]: got d=%h want no output", cyc, o1_ext); end
        else begin
          r = q1.pop_front();
          if ({o1_err, o1_ext} !== r) begin n_fail++; $display("FAIL stream_data_s1[%0d]: got %h want %h", cyc, {o1_err, o1_ext}, r); end
        end
      end
      if (o3_valid && out_ready) begin
        n_cmp++;
        if (q3.size() == 0) begin n_fail++; $display("FAIL stream_extra_s3[%0d]: got d=%h want no output", cyc, o3_ext); end
        else begin
          r = q3.pop_front();
          if ({o3_err, o3_ext} !== r) begin n_fail++; $display("FAIL stream_data_s3[%0d]: got %h want %h", cyc, {o3_err, o3_ext}, r); end
        end
      end
      st1 = o1_valid && !out_ready; h1 = o1_ext;
      st3 = o3_valid && !out_ready; h3 = o3_ext;
      if (in_valid && r1_rdy) begin
        q1.push_back(ref_ext(cop, cimm, csh));
        if (cop > 3'd4 && e1 < 255) e1++;
      end
      if (in_valid && r3_rdy) begin
        q3.push_back(ref_ext(cop, cimm, csh));
        if (cop > 3'd4 && e3 < 3) e3++;
        sent++;
        cop = 3'($urandom_range(0, 7)); cimm = 16'($urandom); csh = 5'($urandom);
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_cmp++; if (sent != n || q1.size() != 0 || q3.size() != 0) begin
      n_fail++; $display("FAIL stream_complete: got sent=%0d left=%0d/%0d want sent=%0d left=0/0", sent, q1.size(), q3.size(), n);
    end
  endtask

  task automatic test_flush();
    logic [32:0] r;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; op = 3'($urandom_range(0, 4)); imm = 16'($urandom); shamt = 5'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1; flush = 1'b1; op = 3'd5; imm = 16'($urandom);
    #3;
    n_cmp++; if (r1_rdy !== 1'b0 || r3_rdy !== 1'b0) begin
      n_fail++; $display("FAIL flush_ready: got s1=%b s3=%b want 0/0", r1_rdy, r3_rdy);
    end
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++; if (o1_valid !== 1'b0 || o3_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_clear: got s1=%b s3=%b want 0/0", o1_valid, o3_valid);
    end
    n_cmp++; if (o1_cnt !== e1[7:0] || o3_cnt !== e3[1:0]) begin
      n_fail++; $display("FAIL flush_cnt: got %0d/%0d want %0d/%0d", o1_cnt, o3_cnt, e1, e3);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_cmp++; if (o1_valid !== 1'b0 || o3_valid !== 1'b0) begin
        n_fail++; $display("FAIL flush_empty[%0d]: got s1=%b s3=%b want 0/0", c, o1_valid, o3_valid);
      end
    end
    in_valid = 1'b1; op = 3'($urandom_range(0, 4)); imm = 16'($urandom); shamt = 5'($urandom);
    r = ref_ext(op, imm, shamt);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_cmp++; if (o1_valid !== (c == 0) || (c == 0 && {o1_err, o1_ext} !== r)) begin
        n_fail++; $display("FAIL post_flush_s1[%0d]: got v=%b d=%h want v=%b d=%h", c, o1_valid, {o1_err, o1_ext}, (c == 0), r);
      end
      n_cmp++; if (o3_valid !== (c == 2) || (c == 2 && {o3_err, o3_ext} !== r)) begin
        n_fail++; $display("FAIL post_flush_s3[%0d]: got v=%b d=%h want v=%b d=%h", c, o3_valid, {o3_err, o3_ext}, (c == 2), r);
      end
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1; op = (c == 1) ? 3'd6 : 3'($urandom_range(0, 4));
      imm = 16'($urandom) | 16'h0100; shamt = 5'($urandom);
      @(posedge clk); #1;
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (o1_valid !== 1'b0 || o1_ext !== 32'd0 || o1_err !== 1'b0 || o1_cnt !== 8'd0) begin
      n_fail++; $display("FAIL reset_mid_s1: got v=%b d=%h e=%b c=%0d want all 0", o1_valid, o1_ext, o1_err, o1_cnt);
    end
    n_cmp++; if (o3_valid !== 1'b0 || o3_ext !== 32'd0 || o3_err !== 1'b0 || o3_cnt !== 2'd0) begin
      n_fail++; $display("FAIL reset_mid_s3: got v=%b d=%h e=%b c=%0d want all 0", o3_valid, o3_ext, o3_err, o3_cnt);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    e1 = 0; e3 = 0;
    #2;
    n_cmp++; if (r1_rdy !== 1'b1 || r3_rdy !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_ready: got s1=%b s3=%b want 1/1", r1_rdy, r3_rdy);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_cmp++; if (o1_valid !== 1'b0 || o3_valid !== 1'b0) begin
        n_fail++; $display("FAIL reset_mid_drop[%0d]: got s1=%b s3=%b want 0/0", c, o1_valid, o3_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_illegal();
    test_modes();
    test_stream(10, 4, 4);
    test_stream(30, 9, 6);
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by time limit want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
